// File: rtl/div_unit_seq.sv
// ---------------------------------------------------------------------------
// div_unit_seq
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU). It performs
// one restoring-division step per cycle, then applies a single sign-fix
// cycle. Divide-by-zero and signed overflow are resolved in the issue cycle.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     request; sampled only while idle
//   op        00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   dividend  rs1 value, sampled with start
//   divisor   rs2 value, sampled with start
//   busy      operation in progress; start is ignored
//   done      one-cycle pulse, result valid
//   result    quotient or remainder; holds until the next done
// ---------------------------------------------------------------------------
module div_unit_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  // State and datapath registers
  state_t           r_state;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_qneg;
  logic             r_rneg;
  logic [WIDTH-1:0] r_result;
  logic             r_done;
  logic             r_busy;

  // Next-state values
  state_t           w_state_nxt;
  logic [1:0]       w_op_nxt;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt;
  logic [WIDTH-1:0] w_dvsr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_qneg_nxt;
  logic             w_rneg_nxt;
  logic [WIDTH-1:0] w_result_nxt;
  logic             w_done_nxt;
  logic             w_busy_nxt;

  // Operand conditioning at issue
  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dvs_mag;
  logic             w_div_zero;
  logic             w_ovf;
  logic [WIDTH-1:0] w_special_val;

  // Iteration and sign-fix datapath
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_fix_sel;
  logic             w_fix_neg;
  logic [WIDTH-1:0] w_fix_val;

  // Magnitudes and special-case detection; unsigned ops pass operands raw
  assign w_dvd_neg  = ~op[0] & dividend[WIDTH-1];
  assign w_dvs_neg  = ~op[0] & divisor[WIDTH-1];
  assign w_dvd_mag  = w_dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign w_dvs_mag  = w_dvs_neg ? (~divisor + WIDTH'(1)) : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = ~op[0] && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                      && (divisor == '1);

  // Divide-by-zero has priority; overflow implies a non-zero divisor anyway
  always_comb begin
    w_special_val = '0;
    if (w_div_zero) begin
      w_special_val = op[1] ? dividend : '1;
    end else begin
      w_special_val = op[1] ? '0 : dividend;
    end
  end

  // One restoring step: the extra MSB of the trial difference is the borrow
  assign w_rem_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_trial     = w_rem_shift - {1'b0, r_dvsr};

  // Final selection and sign correction
  assign w_fix_sel = r_op[1] ? r_rem : r_quo;
  assign w_fix_neg = ~r_op[0] & (r_op[1] ? r_rneg : r_qneg);
  assign w_fix_val = w_fix_neg ? (~w_fix_sel + WIDTH'(1)) : w_fix_sel;

  // Next-state and register-update logic
  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_dvsr_nxt   = r_dvsr;
    w_cnt_nxt    = r_cnt;
    w_qneg_nxt   = r_qneg;
    w_rneg_nxt   = r_rneg;
    w_result_nxt = r_result;
    w_done_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_op_nxt = op;
          if (w_div_zero || w_ovf) begin
            w_result_nxt = w_special_val;
            w_done_nxt   = 1'b1;
          end else begin
            w_dvsr_nxt  = w_dvs_mag;
            w_quo_nxt   = w_dvd_mag;
            w_rem_nxt   = '0;
            w_cnt_nxt   = CNT_W'(WIDTH);
            w_qneg_nxt  = w_dvd_neg ^ w_dvs_neg;
            w_rneg_nxt  = w_dvd_neg;
            w_state_nxt = S_CALC;
          end
        end
      end

      S_CALC: begin
        if (!w_trial[WIDTH]) begin
          w_rem_nxt = w_trial[WIDTH-1:0];
        end else begin
          w_rem_nxt = w_rem_shift[WIDTH-1:0];
        end
        w_quo_nxt = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = S_FIX;
        end
      end

      S_FIX: begin
        w_result_nxt = w_fix_val;
        w_done_nxt   = 1'b1;
        w_state_nxt  = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_cnt    <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
      r_result <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_dvsr   <= w_dvsr_nxt;
      r_cnt    <= w_cnt_nxt;
      r_qneg   <= w_qneg_nxt;
      r_rneg   <= w_rneg_nxt;
      r_result <= w_result_nxt;
      r_done   <= w_done_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_div_unit_seq.sv
// ---------------------------------------------------------------------------
// tb_div_unit_seq
// Self-checking bench for div_unit_seq (WIDTH=32): directed RV32M cases plus
// randomized operations compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_div_unit_seq;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] result;

  int n_vec;
  int n_err;

  div_unit_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics using plain signed/unsigned arithmetic
  function automatic logic [W-1:0] model(input logic [1:0] o,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'h0 : a;
    if (!o[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return o[1] ? W'(r) : W'(q);
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 20));
      4:       return 32'hFFFF_FFFF - W'($urandom_range(0, 20));
      default: return W'($urandom());
    endcase
  endfunction

  // Called just after a clock edge while idle (or in a done cycle)
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
  endtask

  // Issue one op, follow it to done, check result/latency/handshake.
  // With inject set, a foreign start is pulsed in the middle of CALC.
  task automatic run_op(input string tag, input logic [1:0] o,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit inject);
    logic [W-1:0] prev;
    int edges, bcnt, overlap, held_bad;
    bit sp;
    sp       = is_special(o, a, b);
    prev     = result;
    edges    = 0;
    bcnt     = 0;
    overlap  = 0;
    held_bad = 0;
    issue(o, a, b);
    while (!done && edges < 100) begin
      if (busy) bcnt++;
      if (result !== prev) held_bad++;
      if (inject && edges == 5) begin
        op = ~o; dividend = 32'h1234_5678; divisor = 32'h3; start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      edges++;
    end
    if (busy && done) overlap++;
    check({tag, ".result"}, result, model(o, a, b));
    check({tag, ".edges"}, W'(edges), sp ? 32'd0 : W'(W + 1));
    check({tag, ".busy_cycles"}, W'(bcnt), sp ? 32'd0 : W'(W + 1));
    check({tag, ".hold_overlap"}, W'(held_bad + overlap), 32'd0);
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op       = 2'b00;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", W'(busy), 32'd0);
    check("reset.done", W'(done), 32'd0);
    check("reset.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases; consecutive run_op calls are back-to-back
    run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 1'b0);
    run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 1'b0);
    run_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0);
    run_op("div_5_0",    2'b00, 32'd5, 32'd0, 1'b0);
    run_op("remu_5_0",   2'b11, 32'd5, 32'd0, 1'b0);
    run_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_min_m1", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("inject",     2'b01, 32'd1000, 32'd9, 1'b1);

    // Reset in the middle of a DIVU
    run_op("pre_rst",    2'b01, 32'd100, 32'd7, 1'b0);
    issue(2'b01, 32'hDEAD_BEEF, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst.busy", W'(busy), 32'd0);
    check("midrst.done", W'(done), 32'd0);
    check("midrst.result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("postrst.done", W'(done), 32'd0);
    run_op("post_rst", 2'b01, 32'hFFFF_FFFF, 32'h10, 1'b0);

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      logic [1:0] o;
      logic [W-1:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      run_op($sformatf("rnd%0d", i), o, a, b, ($urandom_range(0, 7) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit_seq.md
Name: div_unit_seq

Overview:
- Iterative RV32M divide/remainder unit; executes DIV, DIVU, REM and REMU over multiple cycles.
- Sits in the execute stage beside the ALU.
- Its registered result feeds input_B of the writeback result 2-to-1 mux; the ALU result feeds input_A.
- The pipeline holds issue while busy is high.

Parameters:
WIDTH, 32, operand/result width in bits (even, >= 4)

Ports:
clk        input   1      system clock, rising edge
rst_n      input   1      asynchronous active-low reset
start      input   1      request; sampled only when unit is idle
op         input   2      00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
dividend   input   WIDTH  rs1 value, sampled with start
divisor    input   WIDTH  rs2 value, sampled with start
busy       output  1      operation in progress; start ignored
done       output  1      one-cycle pulse, result valid
result     output  WIDTH  quotient or remainder; holds until next done

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, result=0, all internal registers 0. Deassertion takes effect at the next clock edge.
- States:
  - IDLE: done=0 unless the previous cycle completed an operation.
  - CALC: busy=1.
  - FIX: busy=1.
- IDLE, start=1 at edge E0:
  - Latch op.
  - Compute operand magnitudes: two's-complement absolute value when op[0]=0, raw value when op[0]=1.
  - Record quotient sign = sign(dividend) XOR sign(divisor), signed ops only. Record remainder sign = sign(dividend), signed ops only.
  - Load counter=WIDTH and clear the partial remainder. Go to CALC.
- Special cases are detected at E0 and bypass CALC:
  - divisor==0: quotient = all ones; remainder = dividend.
  - Signed overflow (op[0]=0, dividend = 1 followed by WIDTH-1 zeros, divisor = all ones): quotient = dividend; remainder = 0.
  - result is loaded at E0 and done=1 in the following cycle (latency 1). State stays IDLE; busy never rises.
- CALC: one restoring-division step per edge.
  - Shift {rem, quo} left by 1.
  - Trial-subtract the divisor magnitude from rem, using a WIDTH+1-bit subtract.
  - Non-negative difference: keep it and set quo LSB=1. Otherwise restore rem and set quo LSB=0.
  - Decrement the counter. After the WIDTH-th step go to FIX.
- FIX (one edge):
  - Select quotient (op[1]=0) or remainder (op[1]=1).
  - Negate if the recorded sign is set; an unsigned op never negates.
  - Register the value into result, pulse done=1, clear busy, go to IDLE.
- Timing: for normal ops, busy=1 during the cycles after E0 through E(WIDTH+1). done=1 in the cycle after E(WIDTH+1), so latency = WIDTH+1 cycles (33 at default).
- done and busy are never high in the same cycle.
- start during busy: ignored; inputs are not resampled.
- start in the same cycle done=1 (state IDLE): accepted; back-to-back operations are allowed.
- result changes only at the edge that raises done (or at reset).
- Reset mid-operation aborts immediately. No done pulse; result=0.

Test Plan:
- DIVU 100/7 -> after 33 cycles done=1, result=14; REMU 100/7 -> result=2; busy high for exactly 33 cycles.
- DIV -7/2 -> result=0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
- Divide by zero: DIV 5/0 -> result=0xFFFFFFFF; REMU 5/0 -> 5; done asserted 1 cycle after start, busy stays 0.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0; latency 1.
- Handshake: pulse start with new operands mid-CALC -> ignored, original result delivered. Start asserted during the done cycle -> second op accepted, second done follows 33 cycles later.
- Reset mid-operation: assert rst_n=0 at cycle 10 of a DIVU -> busy, done and result go to 0 immediately. A new op after release completes correctly (0xFFFFFFFF/0x10 -> 0x0FFFFFFF).
